bouncing_box_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 18 +
 rtl/box_axis_motion.sv | 77 +++++++
 rtl/bouncing_box_gen.sv | 124 ++++++++++++
 tb/tb_bouncing_box_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default active-area geometry, coordinate width,
// colour constants and the motion direction type.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  // Direction of travel along one axis.
  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_e;

endpackage : vga_pkg

// File: rtl/box_axis_motion.sv
// One axis of box motion: position of the box's leading (top/left) corner
// and its direction. On each unpaused tick the box moves STEP pixels.
// A move that would overshoot clamps to the wall and reverses direction.
// 'bounce' is a combinational pulse that is high during the tick cycle in
// which that reversal is about to be registered. The parent can therefore
// count it on the same edge that moves the box.
// STEP must be at least 1 and below the box size, so that a clamp never skips a wall.
module box_axis_motion
  import vga_pkg::*;
#(
  parameter int LIMIT = 624,
  parameter int STEP  = 2,
  parameter int INIT  = 312
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               pause,
  output logic [COORD_W-1:0] pos,
  output logic               bounce
);

  localparam logic [COORD_W:0]   LIMIT_EXT = (COORD_W + 1)'(LIMIT);
  localparam logic [COORD_W-1:0] LIMIT_C   = COORD_W'(LIMIT);
  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] INIT_C    = COORD_W'(INIT);

  dir_e               dir;
  dir_e               dir_nxt;
  logic [COORD_W-1:0] pos_nxt;
  logic [COORD_W:0]   inc_sum;

  // One extra bit keeps pos+STEP from wrapping before the limit compare.
  assign inc_sum = {1'b0, pos} + {1'b0, STEP_C};

  // Next position/direction and bounce detection for this axis.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    pos_nxt = pos;
    dir_nxt = dir;
    bounce  = 1'b0;
    if (tick && !pause) begin
      if (dir == DIR_INC) begin
        if (inc_sum <= LIMIT_EXT) begin
          pos_nxt = inc_sum[COORD_W-1:0];
        end else begin
          pos_nxt = LIMIT_C;
          dir_nxt = DIR_DEC;
          bounce  = 1'b1;
        end
      end else begin
        if (pos >= STEP_C) begin
          pos_nxt = pos - STEP_C;
        end else begin
          pos_nxt = '0;
          dir_nxt = DIR_INC;
          bounce  = 1'b1;
        end
      end
    end
  end

  // Position/direction registers; reset centres the box moving forward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= INIT_C;
      dir <= DIR_INC;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples the pre-edge values regardless of statement order.
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

endmodule : box_axis_motion

// File: rtl/bouncing_box_gen.sv
// Animated test-pattern source for the VGA RGB buffer. It draws a white
// border and a square box on black. The box moves once per frame, bounces
// off the screen edges and counts its bounces. The colour output is
// registered, so it lags the pixel coordinates by one clk.
module bouncing_box_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = 16,
  parameter int STEP     = 2,
  parameter int BORDER   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       pause,
  input  logic [2:0] box_color,
  output logic [2:0] B_color,
  output logic [7:0] bounce_cnt
);

  localparam int X_LIMIT = H_ACTIVE - BOX_SIZE;
  localparam int Y_LIMIT = V_ACTIVE - BOX_SIZE;

  localparam logic [COORD_W-1:0] V_ACTIVE_C = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W:0]   BOX_EXT    = (COORD_W + 1)'(BOX_SIZE);
  localparam logic [COORD_W-1:0] BORDER_C   = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] H_EDGE_C   = COORD_W'(H_ACTIVE - BORDER);
  localparam logic [COORD_W-1:0] V_EDGE_C   = COORD_W'(V_ACTIVE - BORDER);

  logic               frame_tick;
  logic [COORD_W-1:0] box_x;
  logic [COORD_W-1:0] box_y;
  logic               bounce_x;
  logic               bounce_y;
  logic [7:0]         bounce_sum;
  logic [COORD_W:0]   px_ext;
  logic [COORD_W:0]   py_ext;
  logic [COORD_W:0]   box_x_end;
  logic [COORD_W:0]   box_y_end;
  logic               box_hit;
  logic               border_hit;
  logic [2:0]         color_nxt;

  // First pixel of vertical blanking: motion updates land outside the
  // visible area, so every visible pixel of a frame sees one box position.
  assign frame_tick = p_tick && (pixel_x == '0) && (pixel_y == V_ACTIVE_C);

  box_axis_motion #(
    .LIMIT (X_LIMIT),
    .STEP  (STEP),
    .INIT  (X_LIMIT / 2)
  ) u_motion_x (
    .clk    (clk),
    .reset  (reset),
    .tick   (frame_tick),
    .pause  (pause),
    .pos    (box_x),
    .bounce (bounce_x)
  );

  box_axis_motion #(
    .LIMIT (Y_LIMIT),
    .STEP  (STEP),
    .INIT  (Y_LIMIT / 2)
  ) u_motion_y (
    .clk    (clk),
    .reset  (reset),
    .tick   (frame_tick),
    .pause  (pause),
    .pos    (box_y),
    .bounce (bounce_y)
  );

  // A corner hit bounces both axes at once and counts twice.
  assign bounce_sum = {7'd0, bounce_x} + {7'd0, bounce_y};

  // Wrapping bounce counter, updated on the same edge as the box position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bounce_cnt <= '0;
    end else begin
      bounce_cnt <= bounce_cnt + bounce_sum;
    end
  end

  // Hit tests use one extra bit so box_x+BOX_SIZE cannot wrap.
  assign px_ext    = {1'b0, pixel_x};
  assign py_ext    = {1'b0, pixel_y};
  assign box_x_end = {1'b0, box_x} + BOX_EXT;
  assign box_y_end = {1'b0, box_y} + BOX_EXT;

  assign box_hit = (px_ext >= {1'b0, box_x}) && (px_ext < box_x_end) &&
                   (py_ext >= {1'b0, box_y}) && (py_ext < box_y_end);

  assign border_hit = (pixel_x < BORDER_C) || (pixel_x >= H_EDGE_C) ||
                      (pixel_y < BORDER_C) || (pixel_y >= V_EDGE_C);

  // Colour priority: blanking, then box (drawn over border), then border.
  always_comb begin
    color_nxt = COLOR_BLACK;
    if (!video_on) begin
      color_nxt = COLOR_BLACK;
    end else if (box_hit) begin
      color_nxt = box_color;
    end else if (border_hit) begin
      color_nxt = COLOR_WHITE;
    end
  end

  // Output colour register feeding the RGB buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      B_color <= COLOR_BLACK;
    end else begin
      B_color <= color_nxt;
    end
  end

endmodule : bouncing_box_gen

// File: tb/tb_bouncing_box_gen.sv
// Self-checking bench for bouncing_box_gen. Frame ticks are driven directly,
// so each tick costs a single clk. Expected values come from constants and a
// small motion model. They are queued when stimulus is applied and compared
// just after the edge that produces them.
module tb_bouncing_box_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       pause;
  logic [2:0] box_color;
  logic [2:0] B_color;
  logic [7:0] bounce_cnt;

  bouncing_box_gen dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .pause      (pause),
    .box_color  (box_color),
    .B_color    (B_color),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    is_cnt;
    int    exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Motion model.
  int m_x, m_y, m_cnt;
  bit m_dx, m_dy;
  bit saw_corner = 1'b0;
  bit saw_wrap   = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_color(input int x, input int y, input bit von,
                                   input int bx, input int by);
    if (!von) return 0;
    if (x >= bx && x < bx + 16 && y >= by && y < by + 16) return int'(box_color);
    if (x < 4 || x >= 636 || y < 4 || y >= 476) return 7;
    return 0;
  endfunction

  task automatic push(input string tag, input bit is_cnt, input int exp);
    sb_t e;
    e.tag    = tag;
    e.is_cnt = is_cnt;
    e.exp    = exp;
    sb.push_back(e);
  endtask

  // Advance one clk and compare every queued expectation.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.is_cnt ? int'(bounce_cnt) : int'(B_color), e.exp);
    end
  endtask

  task automatic model_reset();
    m_x = 312; m_y = 232; m_dx = 1'b1; m_dy = 1'b1; m_cnt = 0;
  endtask

  task automatic axis(inout int p, inout bit d, input int lim, output int b);
    b = 0;
    if (d) begin
      if (p + 2 <= lim) p = p + 2;
      else begin p = lim; d = 1'b0; b = 1; end
    end else begin
      if (p >= 2) p = p - 2;
      else begin p = 0; d = 1'b1; b = 1; end
    end
  endtask

  task automatic drive_pixel(input int x, input int y, input bit von,
                             input int bx, input int by, input string tag);
    @(negedge clk);
    p_tick   = 1'b0;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    push(tag, 1'b0, exp_color(x, y, von, bx, by));
    step();
  endtask

  // One frame tick; 'full' forces the colour and counter checks every tick,
  // otherwise the counter is only checked when the model bounces.
  task automatic do_tick(input bit full);
    int bx, by;
    @(negedge clk);
    p_tick   = 1'b1;
    pixel_x  = 10'd0;
    pixel_y  = 10'd480;
    video_on = 1'b0;
    if (full) push("tick_color", 1'b0, 0);
    bx = 0; by = 0;
    if (!pause) begin
      axis(m_x, m_dx, 624, bx);
      axis(m_y, m_dy, 464, by);
    end
    if (bx + by == 2) saw_corner = 1'b1;
    if (m_cnt + bx + by > 255) saw_wrap = 1'b1;
    m_cnt = (m_cnt + bx + by) % 256;
    if (full || (bx + by) != 0)
      push((bx + by == 2) ? "corner_cnt" : "bounce_cnt", 1'b1, m_cnt);
    step();
  endtask

  // Probe the box corners and the pixels just outside it.
  task automatic check_box(input int bx, input int by);
    drive_pixel(bx, by, 1'b1, bx, by, "box_tl");
    drive_pixel(bx + 15, by + 15, 1'b1, bx, by, "box_br");
    if (bx > 0)        drive_pixel(bx - 1, by, 1'b1, bx, by, "box_left_out");
    if (by > 0)        drive_pixel(bx, by - 1, 1'b1, bx, by, "box_top_out");
    if (bx + 16 < 640) drive_pixel(bx + 16, by, 1'b1, bx, by, "box_right_out");
    if (by + 16 < 480) drive_pixel(bx, by + 16, 1'b1, bx, by, "box_bot_out");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    p_tick    = 1'b0;
    pixel_x   = '0;
    pixel_y   = '0;
    video_on  = 1'b0;
    pause     = 1'b0;
    box_color = 3'b100;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_color", int'(B_color), 0);
    check("reset_cnt", int'(bounce_cnt), 0);
    reset = 1'b1;

    // Colour lookup at the reset position.
    check_box(312, 232);
    drive_pixel(312, 232, 1'b1, 312, 232, "lookup_box");
    drive_pixel(0, 0, 1'b1, 312, 232, "lookup_border");
    drive_pixel(100, 100, 1'b1, 312, 232, "lookup_bg");
    drive_pixel(312, 232, 1'b0, 312, 232, "lookup_blank");

    // First tick moves the box diagonally.
    do_tick(1'b1);
    check_box(314, 234);

    // Asynchronous reset mid-line, between clock edges.
    drive_pixel(314, 234, 1'b1, 314, 234, "pre_async_rst");
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_color", int'(B_color), 0);
    check("async_rst_cnt", int'(bounce_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check_box(312, 232);
    do_tick(1'b1);
    check_box(314, 234);

    // Y bounce: ticks 2..116, then 117 and 118.
    for (int i = 2; i <= 116; i++) do_tick(1'b0);
    check_box(544, 464);
    do_tick(1'b1);
    check("y_bounce_cnt", int'(bounce_cnt), 1);
    check_box(546, 464);
    do_tick(1'b1);
    check_box(548, 462);

    // X bounce: ticks 119..156, then 157.
    for (int i = 119; i <= 156; i++) do_tick(1'b0);
    check_box(624, 386);
    do_tick(1'b1);
    check("x_bounce_cnt", int'(bounce_cnt), 2);
    check_box(624, 384);

    // Pause across three frame ticks, then release.
    pause = 1'b1;
    for (int i = 0; i < 3; i++) do_tick(1'b1);
    check("pause_cnt", int'(bounce_cnt), 2);
    check_box(624, 384);
    pause = 1'b0;
    do_tick(1'b1);
    check_box(622, 382);

    // Long run until the model sees a corner hit and a counter wrap.
    for (int i = 0; i < 40000 && !(saw_corner && saw_wrap); i++)
      do_tick((i % 1000) == 0);
    if (!saw_corner) check("corner_reached", 0, 1);
    if (!saw_wrap)   check("wrap_reached", 0, 1);
    check("final_cnt", int'(bounce_cnt), m_cnt);
    check_box(m_x, m_y);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_bouncing_box_gen
